lsu_ctrl: RTL and testbench

//  Load/store unit sitting directly downstream of the ALU: consumes the ALU Result as the

---
 rtl/lsu_ctrl.sv | 178 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit behind the ALU.
// Drives a word-wide data port, returns extended load data.
module lsu_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned LIM = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic          st_q;
  logic [2:0]    f3_q;
  logic [1:0]    lo_q;
  logic [CW-1:0] cnt;

  logic          ill;
  logic          mis;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   ld;
  logic          tmo;

  always_comb begin
    ill = is_store ? (funct3 > 3'd2)
                   : (funct3 == 3'd3 || funct3[2:1] == 2'b11);
    mis = (funct3[1:0] == 2'b01 && addr[0]) ||
          (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  end

  always_comb begin
    be_n = 4'b1111;
    wd_n = wdata;
    unique case (1'b1)
      funct3[1:0] == 2'b00: begin
        be_n = 4'b0001 << addr[1:0];
        wd_n = {4{wdata[7:0]}};
      end
      funct3[1:0] == 2'b01: begin
        be_n = 4'b0011 << {addr[1], 1'b0};
        wd_n = {2{wdata[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = wdata;
      end
    endcase
    if (!is_store)
      be_n = 4'b1111;
  end

  // f3_q[2] set means the unsigned load variants
  always_comb begin
    lane_b = mem_rdata[{lo_q, 3'b000} +: 8];
    lane_h = mem_rdata[{lo_q[1], 4'b0000} +: 16];
    ld     = mem_rdata;
    unique case (1'b1)
      f3_q[1:0] == 2'b00:
        ld = {{24{~f3_q[2] & lane_b[7]}}, lane_b};
      f3_q[1:0] == 2'b01:
        ld = {{16{~f3_q[2] & lane_h[15]}}, lane_h};
      default:
        ld = mem_rdata;
    endcase
  end

  assign tmo = (MAX_WAIT != 0) && (cnt == CW'(LIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      st_q      <= 1'b0;
      f3_q      <= '0;
      lo_q      <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE, RESP: begin
          if (start) begin
            st_q <= is_store;
            f3_q <= funct3;
            lo_q <= addr[1:0];
            busy <= 1'b1;
            if (ill) begin
              state    <= RESP;
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= 2'b10;
            end else if (mis) begin
              state    <= RESP;
              done     <= 1'b1;
              err      <= 1'b1;
              err_code <= 2'b01;
            end else begin
              state     <= ACCESS;
              done      <= 1'b0;
              err       <= 1'b0;
              err_code  <= 2'b00;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wd_n;
              cnt       <= '0;
            end
          end else if (state == RESP) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        ACCESS: begin
          // a response on the limit cycle still counts as success
          if (mem_ready) begin
            state    <= RESP;
            mem_req  <= 1'b0;
            done     <= 1'b1;
            err      <= 1'b0;
            err_code <= 2'b00;
            if (!st_q)
              rdata <= ld;
          end else if (tmo) begin
            state    <= RESP;
            mem_req  <= 1'b0;
            done     <= 1'b1;
            err      <= 1'b1;
            err_code <= 2'b11;
          end else if (MAX_WAIT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized bench for lsu_ctrl.
// Expected values come from a plain arithmetic model of the LSU.
module tb_lsu_ctrl;

  localparam int MW = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  err_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .is_store(is_store),
    .funct3(funct3),
    .addr(addr),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .rdata(rdata),
    .err(err),
    .err_code(err_code),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_be(mem_be),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    v = rd;
    if (f3 == 0 || f3 == 4) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (f3 == 0 && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (f3 == 1 || f3 == 5) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (f3 == 1 && v >= 32768) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic run_op(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int wt, input logic [31:0] rd);
    logic ill;
    logic mis;
    logic [3:0] be;
    logic [31:0] wexp;
    ill = st ? (f3 > 2) : (f3 == 3 || f3 >= 6);
    mis = !ill && ((f3 % 4 == 1 && a % 2 != 0) ||
                   (f3 % 4 == 2 && a % 4 != 0));
    be = 4'hF;
    wexp = wd;
    if (st && f3 == 0) begin
      be = 4'(1 << (a % 4));
      wexp = (wd & 32'hFF) * 32'h0101_0101;
    end else if (st && f3 == 1) begin
      be = (a % 4 >= 2) ? 4'hC : 4'h3;
      wexp = (wd & 32'hFFFF) * 32'h0001_0001;
    end
    @(negedge clk);
    start = 1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    start = 0;
    if (ill || mis) begin
      chk("err_done", {31'b0, done}, 1);
      chk("err_req", {31'b0, mem_req}, 0);
      chk("err_flag", {31'b0, err}, 1);
      chk("err_code", {30'b0, err_code}, ill ? 2 : 1);
      chk("err_rdata", rdata, exp_rdata);
      return;
    end
    chk("req", {31'b0, mem_req}, 1);
    chk("we", {31'b0, mem_we}, {31'b0, st});
    chk("maddr", mem_addr, a & ~32'd3);
    chk("be", {28'b0, mem_be}, {28'b0, be});
    if (st) chk("mwdata", mem_wdata, wexp);
    chk("busy", {31'b0, busy}, 1);
    chk("done0", {31'b0, done}, 0);
    for (int k = 0; k < MW; k++) begin
      mem_ready = (k == wt);
      mem_rdata = (k == wt) ? rd : $urandom;
      start = 1'($urandom % 2);
      addr = $urandom; funct3 = 3'($urandom); wdata = $urandom;
      is_store = 1'($urandom);
      @(posedge clk); #1;
      mem_ready = 0; start = 0;
      if (k == wt || k == MW - 1) break;
      chk("hold_req", {31'b0, mem_req}, 1);
      chk("hold_addr", mem_addr, a & ~32'd3);
      chk("hold_be", {28'b0, mem_be}, {28'b0, be});
      chk("hold_done", {31'b0, done}, 0);
    end
    if (wt < MW) begin
      if (!st) exp_rdata = model_load(f3, a, rd);
      chk("ok_err", {31'b0, err}, 0);
      chk("ok_code", {30'b0, err_code}, 0);
    end else begin
      chk("tmo_err", {31'b0, err}, 1);
      chk("tmo_code", {30'b0, err_code}, 3);
    end
    chk("fin_done", {31'b0, done}, 1);
    chk("fin_req", {31'b0, mem_req}, 0);
    chk("fin_busy", {31'b0, busy}, 1);
    chk("rdata", rdata, exp_rdata);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    start = 0;
    @(posedge clk); #1;
    chk("idle_busy", {31'b0, busy}, 0);
    chk("idle_done", {31'b0, done}, 0);
  endtask

  initial begin
    rst_n = 1; start = 0; is_store = 0; funct3 = 0;
    addr = 0; wdata = 0; mem_ready = 0; mem_rdata = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_code", {30'b0, err_code}, 0);
    chk("rst_req", {31'b0, mem_req}, 0);
    chk("rst_we", {31'b0, mem_we}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_be", {28'b0, mem_be}, 0);
    chk("rst_mwdata", mem_wdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;

    run_op(0, 2, 32'h100, 0, 0, 32'hDEAD_BEEF);
    chk("lw_abs", rdata, 32'hDEAD_BEEF);
    idle_cycle();
    run_op(0, 0, 32'h103, 0, 1, 32'h80FF_0000);
    chk("lb_abs", rdata, 32'hFFFF_FF80);
    run_op(0, 4, 32'h103, 0, 0, 32'h80FF_0000);
    chk("lbu_abs", rdata, 32'h0000_0080);
    run_op(0, 5, 32'h102, 0, 2, 32'h80FF_0000);
    chk("lhu_abs", rdata, 32'h0000_80FF);
    run_op(1, 1, 32'h206, 32'h1234_ABCD, 3, 32'h5555_5555);
    chk("sh_kept", rdata, 32'h0000_80FF);
    run_op(0, 2, 32'h101, 0, 0, 0);
    run_op(1, 3, 32'h200, 0, 0, 0);
    run_op(0, 2, 32'h300, 0, 10, 32'h1111_2222);
    idle_cycle();

    @(negedge clk);
    start = 1; is_store = 0; funct3 = 2; addr = 32'h400;
    @(posedge clk); #1;
    start = 0;
    chk("pre_rst_req", {31'b0, mem_req}, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_req", {31'b0, mem_req}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_done", {31'b0, done}, 0);
    exp_rdata = '0;
    @(negedge clk) rst_n = 1;
    mem_ready = 1;
    @(posedge clk); #1;
    mem_ready = 0;
    chk("post_rst_done", {31'b0, done}, 0);
    chk("post_rst_rdata", rdata, exp_rdata);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom % 2 == 0) a = a & ~32'd3;
      run_op(1'($urandom), 3'($urandom), a, $urandom,
             $urandom_range(0, MW + 1), $urandom);
      if ($urandom % 3 == 0) idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
